// File: rtl/gcd_sequencer.sv
// gcd_sequencer: controller for a subtract-based GCD datapath.
// It accepts an operand pair, steers a shared external combinational subtractor
// once per cycle until both operands are equal, and then returns the GCD
// together with the number of subtractions performed.
module gcd_sequencer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_gcd,
   output logic [WIDTH-1:0] out_iters,
   output logic             out_err,
   output logic [WIDTH-1:0] sub_in1,
   output logic [WIDTH-1:0] sub_in2,
   input  logic [WIDTH-1:0] sub_out
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] ra, rb, cnt;
   logic [WIDTH-1:0] ra_nx, rb_nx, cnt_nx;
   logic [WIDTH-1:0] gcd_q, iters_q;
   logic [WIDTH-1:0] gcd_nx, iters_nx;
   logic             err_q, err_nx;
   logic [WIDTH-1:0] cnt_inc;

   // Handshake flags follow directly from the state.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_gcd   = gcd_q;
   assign out_iters = iters_q;
   assign out_err   = err_q;

   // Present the larger operand as minuend so the difference never wraps.
   always_comb begin
      if (ra >= rb) begin
         sub_in1 = ra;
         sub_in2 = rb;
      end else begin
         sub_in1 = rb;
         sub_in2 = ra;
      end
   end

   // Iteration count saturates at all-ones as a guard against wrap.
   assign cnt_inc = (cnt == '1) ? cnt : cnt + WIDTH'(1);

   // Next-state and datapath update logic.
   always_comb begin
      state_nx = state;
      ra_nx    = ra;
      rb_nx    = rb;
      cnt_nx   = cnt;
      gcd_nx   = gcd_q;
      iters_nx = iters_q;
      err_nx   = err_q;
      case (state)
         IDLE: begin
            if (in_valid) begin
               ra_nx  = in_a;
               rb_nx  = in_b;
               cnt_nx = '0;
               if (in_a == '0 && in_b == '0) begin
                  state_nx = DONE;
                  gcd_nx   = '0;
                  iters_nx = '0;
                  err_nx   = 1'b1;
               end else if (in_a == '0 || in_b == '0) begin
                  // One operand is zero: the other one is the GCD.
                  state_nx = DONE;
                  gcd_nx   = in_a | in_b;
                  iters_nx = '0;
                  err_nx   = 1'b0;
               end else begin
                  state_nx = RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_nx = IDLE;
            end else if (ra == rb) begin
               state_nx = DONE;
               gcd_nx   = ra;
               iters_nx = cnt;
               err_nx   = 1'b0;
            end else if (ra > rb) begin
               ra_nx  = sub_out;
               cnt_nx = cnt_inc;
            end else begin
               rb_nx  = sub_out;
               cnt_nx = cnt_inc;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Operand, counter and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ra      <= '0;
         rb      <= '0;
         cnt     <= '0;
         gcd_q   <= '0;
         iters_q <= '0;
         err_q   <= 1'b0;
      end else begin
         ra      <= ra_nx;
         rb      <= rb_nx;
         cnt     <= cnt_nx;
         gcd_q   <= gcd_nx;
         iters_q <= iters_nx;
         err_q   <= err_nx;
      end
   end

endmodule

// File: tb/tb_gcd_sequencer.sv
// tb_gcd_sequencer: directed bench for gcd_sequencer with a behavioural
// subtractor attached to the sub_in1/sub_in2/sub_out ports.
module tb_gcd_sequencer;

   localparam int unsigned W = 16;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         abort;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_gcd;
   logic [W-1:0] out_iters;
   logic         out_err;
   logic [W-1:0] sub_in1;
   logic [W-1:0] sub_in2;
   logic [W-1:0] sub_out;

   int checks = 0;
   int passes = 0;

   gcd_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_gcd   (out_gcd),
      .out_iters (out_iters),
      .out_err   (out_err),
      .sub_in1   (sub_in1),
      .sub_in2   (sub_in2),
      .sub_out   (sub_out)
   );

   // External combinational subtractor.
   assign sub_out = sub_in1 - sub_in2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a pair for the accepting edge (edge 0), then scramble the inputs.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_a     = 16'h5A5A;
      in_b     = 16'hA5A5;
   endtask

   // Count further edges until out_valid; an expired budget is a failure.
   task automatic wait_valid(input int maxe, output int n);
      n = 0;
      while (!out_valid && n < maxe) begin
         tick();
         n++;
      end
      if (!out_valid) check("timeout", 32'd0, 32'd1);
   endtask

   // Complete the result handshake and confirm return to IDLE.
   task automatic take(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int n;
      int bad;
      logic [W-1:0] g0, i0;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; abort = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_gcd", 32'(out_gcd), 32'd0);
      check("rst_iters", 32'(out_iters), 32'd0);
      check("rst_err", 32'(out_err), 32'd0);
      check("rst_sub_in1", 32'(sub_in1), 32'd0);

      // 12/8 -> gcd 4 after 2 subtractions, valid after edge 3.
      send(16'd12, 16'd8);
      check("t1_rdy_low", 32'(in_ready), 32'd0);
      check("t1_sub1_a", 32'(sub_in1), 32'd12);
      check("t1_sub2_a", 32'(sub_in2), 32'd8);
      tick();
      check("t1_sub1_b", 32'(sub_in1), 32'd8);
      check("t1_sub2_b", 32'(sub_in2), 32'd4);
      wait_valid(50, n);
      check("t1_latency", 32'(n + 1), 32'd3);
      check("t1_gcd", 32'(out_gcd), 32'd4);
      check("t1_iters", 32'(out_iters), 32'd2);
      check("t1_err", 32'(out_err), 32'd0);
      check("t1_rdy_done", 32'(in_ready), 32'd0);
      take("t1");

      // Worst case: all-ones and 1.
      send(16'hFFFF, 16'd1);
      wait_valid(70000, n);
      check("t2_latency", 32'(n), 32'd65535);
      check("t2_gcd", 32'(out_gcd), 32'd1);
      check("t2_iters", 32'(out_iters), 32'd65534);
      take("t2");
      send(16'd9, 16'd9);
      wait_valid(50, n);
      check("t2b_latency", 32'(n), 32'd1);
      check("t2b_gcd", 32'(out_gcd), 32'd9);
      check("t2b_iters", 32'(out_iters), 32'd0);
      take("t2b");

      // Zero operands.
      send(16'd0, 16'd7);
      check("t3_valid_e0", 32'(out_valid), 32'd1);
      check("t3_gcd", 32'(out_gcd), 32'd7);
      check("t3_iters", 32'(out_iters), 32'd0);
      check("t3_err", 32'(out_err), 32'd0);
      take("t3");
      send(16'd0, 16'd0);
      check("t3b_valid_e0", 32'(out_valid), 32'd1);
      check("t3b_gcd", 32'(out_gcd), 32'd0);
      check("t3b_iters", 32'(out_iters), 32'd0);
      check("t3b_err", 32'(out_err), 32'd1);
      take("t3b");

      // Backpressure on the result; abort in DONE must be ignored.
      send(16'd48, 16'd18);
      wait_valid(100, n);
      check("t4_gcd", 32'(out_gcd), 32'd6);
      check("t4_iters", 32'(out_iters), 32'd4);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         abort = (i == 3);
         tick();
         if (!out_valid || in_ready || out_gcd != 16'd6 || out_iters != 16'd4 || out_err) bad++;
      end
      abort = 1'b0;
      check("t4_hold_bad", 32'(bad), 32'd0);
      take("t4");

      // Abort on the 5th RUN edge: no result, outputs unchanged.
      send(16'd100, 16'd3);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (out_valid) bad++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5_idle", 32'(in_ready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (out_valid) bad++;
      end
      check("t5_no_valid", 32'(bad), 32'd0);
      check("t5_gcd_kept", 32'(out_gcd), 32'd6);
      check("t5_iters_kept", 32'(out_iters), 32'd4);
      send(16'd21, 16'd14);
      wait_valid(100, n);
      check("t5b_latency", 32'(n), 32'd3);
      check("t5b_gcd", 32'(out_gcd), 32'd7);
      check("t5b_iters", 32'(out_iters), 32'd2);
      take("t5b");

      // Reset mid-RUN, then reset in DONE.
      send(16'd35, 16'd25);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_run_rdy", 32'(in_ready), 32'd1);
      check("t6_run_vld", 32'(out_valid), 32'd0);
      check("t6_run_gcd", 32'(out_gcd), 32'd0);
      check("t6_run_iters", 32'(out_iters), 32'd0);
      check("t6_run_sub1", 32'(sub_in1), 32'd0);
      send(16'd35, 16'd25);
      wait_valid(100, n);
      g0 = out_gcd;
      i0 = out_iters;
      check("t6_pre_gcd", 32'(g0), 32'd5);
      check("t6_pre_iters", 32'(i0), 32'd4);
      rst = 1'b1;
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b0;
      check("t6_done_rdy", 32'(in_ready), 32'd1);
      check("t6_done_vld", 32'(out_valid), 32'd0);
      check("t6_done_gcd", 32'(out_gcd), 32'd0);
      check("t6_done_iters", 32'(out_iters), 32'd0);
      check("t6_done_err", 32'(out_err), 32'd0);
      send(16'd35, 16'd25);
      wait_valid(100, n);
      check("t6b_latency", 32'(n), 32'd5);
      check("t6b_gcd", 32'(out_gcd), 32'd5);
      check("t6b_iters", 32'(out_iters), 32'd4);
      take("t6b");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
